// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Address field widths, refill FSM states and field slice helpers
// Revision : 1.0
// ============================================================================
package cache_pkg;

    localparam int TAG_W          = 3;
    localparam int IDX_W          = 10;
    localparam int SEL_W          = 2;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_ADDR_W    = TAG_W + IDX_W + SEL_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MEM_REQ = 3'd2,
        ST_FILL    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [LINE_ADDR_W-1:0] a);
        return a[LINE_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [LINE_ADDR_W-1:0] a);
        return a[SEL_W +: IDX_W];
    endfunction

    function automatic logic [SEL_W-1:0] addr_sel(input logic [LINE_ADDR_W-1:0] a);
        return a[SEL_W-1:0];
    endfunction

    function automatic logic [LINE_ADDR_W-1:0] line_addr(input logic [LINE_ADDR_W-1:0] a);
        return {addr_tag(a), addr_idx(a), {SEL_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Brief    : CPU read sequencer: tag lookup, 4-beat line refill, hit/miss stats
// Revision : 1.0
// ============================================================================
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_req,
    input  logic [ADDR_W-1:0]           cpu_addr,
    output logic                        cpu_ready,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic [ADDR_W-1:0]           cache_addr,
    input  logic                        cache_hit,
    input  logic [DATA_W-1:0]           cache_rdata,
    output logic                        cache_fill,
    output logic [4*DATA_W-1:0]         fill_data,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ack,
    input  logic                        mem_rvalid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [STAT_W-1:0]           stat_hits,
    output logic [STAT_W-1:0]           stat_misses
);

    localparam int c_sel_w = ADDR_W - IDX_W - TAG_W;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_sel_w-1:0]    r_beat;
    logic [DATA_W-1:0]     r_buf [WORDS_PER_LINE];
    logic                  r_cpu_ready;
    logic [DATA_W-1:0]     r_cpu_rdata;
    logic                  r_cache_fill;
    logic                  r_mem_req;
    logic                  w_hit_inc;
    logic                  w_miss_inc;
    logic [c_sel_w-1:0]    w_sel;

    assign w_sel      = r_addr[c_sel_w-1:0];
    assign cache_addr = r_addr;
    assign mem_addr   = {r_addr[ADDR_W-1:c_sel_w], {c_sel_w{1'b0}}};
    assign fill_data  = {r_buf[3], r_buf[2], r_buf[1], r_buf[0]};
    assign cpu_ready  = r_cpu_ready;
    assign cpu_rdata  = r_cpu_rdata;
    assign cache_fill = r_cache_fill;
    assign mem_req    = r_mem_req;

    always_comb begin
        w_state_nxt = r_state;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        case (r_state)
            ST_IDLE:    if (cpu_req) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP: begin
                if (cache_hit) begin
                    w_hit_inc   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_miss_inc  = 1'b1;
                    w_state_nxt = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: if (mem_ack) w_state_nxt = ST_FILL;
            ST_FILL:    if (mem_rvalid && (r_beat == 2'd3)) w_state_nxt = ST_WRITE;
            ST_WRITE:   w_state_nxt = ST_RESP;
            ST_RESP:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_beat       <= '0;
            r_cpu_ready  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cache_fill <= 1'b0;
            r_mem_req    <= 1'b0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_cpu_ready  <= (w_state_nxt == ST_RESP);
            r_cache_fill <= (w_state_nxt == ST_WRITE);
            r_mem_req    <= (w_state_nxt == ST_MEM_REQ);
            if ((r_state == ST_IDLE) && cpu_req) begin
                r_addr <= cpu_addr;
            end
            if ((r_state == ST_MEM_REQ) && mem_ack) begin
                r_beat <= '0;
            end
            if ((r_state == ST_FILL) && mem_rvalid) begin
                r_buf[r_beat] <= mem_rdata;
                r_beat        <= r_beat + 1'b1;
            end
            if ((r_state == ST_LOOKUP) && cache_hit) begin
                r_cpu_rdata <= cache_rdata;
            end
            if (r_state == ST_WRITE) begin
                r_cpu_rdata <= r_buf[w_sel];
            end
        end
    end

    sat_counter #(.STAT_W(STAT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit_inc),
        .count (stat_hits)
    );

    sat_counter #(.STAT_W(STAT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss_inc),
        .count (stat_misses)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Brief    : Scoreboard bench for cache_refill_ctrl with directed vectors
// Revision : 1.0
// ============================================================================
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam int c_stat_w = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cpu_req = 1'b0;
    logic [14:0]          cpu_addr = '0;
    logic                 cpu_ready;
    logic [31:0]          cpu_rdata;
    logic [14:0]          cache_addr;
    logic                 cache_hit = 1'b0;
    logic [31:0]          cache_rdata = '0;
    logic                 cache_fill;
    logic [127:0]         fill_data;
    logic                 mem_req;
    logic [14:0]          mem_addr;
    logic                 mem_ack = 1'b0;
    logic                 mem_rvalid = 1'b0;
    logic [31:0]          mem_rdata = '0;
    logic [c_stat_w-1:0]  stat_hits;
    logic [c_stat_w-1:0]  stat_misses;

    cache_refill_ctrl #(.ADDR_W(15), .IDX_W(10), .DATA_W(32), .STAT_W(c_stat_w)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .cache_addr  (cache_addr),
        .cache_hit   (cache_hit),
        .cache_rdata (cache_rdata),
        .cache_fill  (cache_fill),
        .fill_data   (fill_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          exp_cyc;
    } resp_t;

    resp_t        resp_q[$];
    logic [127:0] fill_q[$];
    resp_t        mon_r;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           fill_pulses = 0;
    int           memreq_cycles = 0;
    logic         prev_fill = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected fills/responses as the DUT presents them
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req) memreq_cycles++;
            if (cache_fill) begin
                fill_pulses++;
                check("fill_single_pulse", {127'd0, prev_fill}, 128'd0);
                if (fill_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL fill_unexpected: got fill %0h, expected no fill", fill_data);
                end else begin
                    check("fill_data", fill_data, fill_q.pop_front());
                end
            end
            prev_fill = cache_fill;
            if (cpu_ready) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ready_unexpected: got ready with %0h, expected none", cpu_rdata);
                end else begin
                    mon_r = resp_q.pop_front();
                    check("cpu_rdata", {96'd0, cpu_rdata}, {96'd0, mon_r.data});
                    if (mon_r.exp_cyc >= 0) check("ready_cycle", cyc, mon_r.exp_cyc);
                end
            end
        end else begin
            prev_fill = 1'b0;
        end
    end

    task automatic wait_idle_q(input string name);
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (resp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: got %0d outstanding responses, expected 0", name, resp_q.size());
            resp_q.delete();
        end
    endtask

    task automatic run_hit(input logic [14:0] addr, input logic [31:0] data, input bit chk_lat);
        resp_t e;
        int    mr0;
        wait_idle_q("hit");
        mr0 = memreq_cycles;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; cache_hit = 1'b1; cache_rdata = data;
        e.data = data;
        e.exp_cyc = chk_lat ? cyc + 2 : -1;
        resp_q.push_back(e);
        @(negedge clk);
        cpu_req = 1'b0;
        check("lookup_cache_addr", cache_addr, addr);
        wait_idle_q("hit");
        if (chk_lat) check("hit_no_mem_req", memreq_cycles, mr0);
    endtask

    task automatic run_miss(input logic [14:0] addr, input int ack_dly, input int gap,
                            input bit spurious, input logic [127:0] line, input bit hold,
                            input logic [14:0] alt_addr, input logic [31:0] alt_data);
        resp_t e;
        int    k, n, req_len;
        bit    fast;
        wait_idle_q("miss");
        fast = (ack_dly == 0) && (gap == 0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; cache_hit = 1'b0; cache_rdata = 32'hBAD0_BAD0;
        k = cyc;
        e.data = line[32*addr_sel(addr) +: 32];
        e.exp_cyc = fast ? k + 8 : -1;
        resp_q.push_back(e);
        fill_q.push_back(line);
        if (hold) begin
            e.data = alt_data;
            e.exp_cyc = fast ? k + 11 : -1;
            resp_q.push_back(e);
        end
        @(negedge clk);
        if (!hold) cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_seen", {127'd0, mem_req}, 128'd1);
        check("mem_addr", mem_addr, line_addr(addr));
        req_len = 0;
        for (int i = 0; i < ack_dly; i++) begin
            mem_rvalid = spurious;
            mem_rdata = 32'hDEAD_0000 + i;
            if (mem_req) req_len++;
            @(negedge clk);
        end
        if (mem_req) req_len++;
        mem_ack = 1'b1; mem_rvalid = spurious; mem_rdata = 32'hDEAD_BEEF;
        check("mem_req_held", req_len, ack_dly + 1);
        @(negedge clk);
        mem_ack = 1'b0; mem_rvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (hold && b == 2) cpu_addr = alt_addr;
            mem_rvalid = 1'b1;
            mem_rdata = line[32*b +: 32];
            @(negedge clk);
            mem_rvalid = 1'b0;
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
        check("mem_req_dropped", {127'd0, mem_req}, 128'd0);
        if (hold) begin
            cache_hit = 1'b1; cache_rdata = alt_data;
            n = 0;
            while (!cpu_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            @(negedge clk);
            cpu_req = 1'b0;
            check("reaccept_addr", cache_addr, alt_addr);
        end
        wait_idle_q("miss");
    endtask

    int f0;

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready",  {127'd0, cpu_ready}, 128'd0);
        check("rst_mem_req",    {127'd0, mem_req}, 128'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", {cpu_ready, cache_fill, mem_req, cpu_rdata, cache_addr, mem_addr, stat_hits, stat_misses}, '0);
        check("idle_fill_data", fill_data, 128'd0);

        // Zero-wait miss, word 1 of the line
        run_miss(15'h0001, 0, 0, 1'b0, {32'd14, 32'd10, 32'd12, 32'd16}, 1'b0, '0, '0);
        check("misses_after_miss", stat_misses, 8'd1);
        run_hit(15'h0003, 32'd14, 1'b1);
        check("hits_after_hit", stat_hits, 8'd1);

        // Slow memory with a stray beat while the request is pending
        run_miss(15'h2A5E, 5, 2, 1'b1, {32'hA4A4_0004, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001},
                 1'b0, '0, '0);

        // Request held high through a miss, address changed mid-fill
        run_miss(15'h1235, 0, 0, 1'b0, {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000},
                 1'b1, 15'h0402, 32'hBEEF_0402);
        check("misses_total", stat_misses, 8'd3);
        check("hits_total", stat_hits, 8'd2);

        // Reset in the middle of a line fill
        wait_idle_q("pre_reset");
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 15'h0100; cache_hit = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        f0 = 0;
        while (!mem_req && f0 < 20) begin
            @(negedge clk);
            f0++;
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_0000;
        @(negedge clk);
        mem_rdata = 32'h5555_0001;
        @(negedge clk);
        mem_rvalid = 1'b0;
        f0 = fill_pulses;
        rst = 1'b0;
        @(negedge clk);
        check("midfill_rst_outputs", {cpu_ready, cache_fill, mem_req, cpu_rdata, cache_addr, mem_addr, stat_hits, stat_misses}, '0);
        check("midfill_rst_fill_data", fill_data, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h6666_0000;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (6) @(negedge clk);
        check("no_fill_after_reset", fill_pulses, f0);
        check("no_mem_req_in_idle", {127'd0, mem_req}, 128'd0);

        run_hit(15'h0105, 32'hCAFE_0105, 1'b1);
        check("hits_after_reset", stat_hits, 8'd1);
        run_miss(15'h7FFF, 0, 0, 1'b0, {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000},
                 1'b0, '0, '0);
        check("misses_after_reset", stat_misses, 8'd1);

        // Saturate the hit counter
        for (int i = 0; i < (1 << c_stat_w) + 3; i++) begin
            run_hit(15'(i), 32'(i) ^ 32'h00FF_00FF, 1'b0);
        end
        check("hits_saturated", stat_hits, 8'hFF);
        run_hit(15'h0042, 32'h0000_0042, 1'b1);
        check("hits_stay_saturated", stat_hits, 8'hFF);
        check("misses_unchanged", stat_misses, 8'd1);

        wait_idle_q("final");
        check("fill_queue_drained", fill_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
